seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment driver. Accepts a binary value on a load strobe
//  and converts it sequentially (double-dabble) to BCD, or passes it through as hex.
//  Updates all digits atomically, then time-multiplexes NUM_DIGITS common-anode digits.
//  Adds leading-zero blanking, hex mode, overflow indication and a busy handshake.
// PARAMETERS
//  NUM_DIGITS  8       digits driven, 1..8
//  SCAN_DIV    100000  clk cycles each digit stays selected, >=1
//  IN_W        20      width of binary input value, 1..32
//  BLANK_LZ    1       1 = blank leading zeros, 0 = show them
// PORTS
//  clk       in   1           system clock, all logic on posedge
//  rst_n     in   1           synchronous reset, active-low
//  load      in   1           1-cycle strobe: capture value/mode (accepted only when busy=0)
//  value     in   IN_W        binary value to display
//  mode      in   1           0 = decimal, 1 = hex
//  busy      out  1           conversion in progress, load ignored
//  oData     out  7           segments {g,f,e,d,c,b,a}, active-low, registered
//  position  out  NUM_DIGITS  digit select, active-low one-hot, bit0 = least significant digit
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): digit regs=0, scan_cnt=0, idx=0, busy=0, position=~1 (digit0),
//   oData=7'b1000000. Any conversion in flight is aborted; no pending load survives reset.
//  Load: load&&!busy at edge t captures value, mode; busy=1 from t+1.
//   decimal: busy high exactly IN_W cycles (one shift-add step per cycle);
//   hex: busy high exactly 1 cycle.
//   Digit regs update on the edge busy falls; old digits are shown until then (no partial update).
//   load while busy: ignored, no queueing.
//  Overflow is checked at capture.
//   decimal: value > 10^NUM_DIGITS-1; hex: any value bit at index >= 4*NUM_DIGITS.
//   On overflow every digit shows dash 7'b0111111 when the update occurs.
//  Scan: scan_cnt counts 0..SCAN_DIV-1. On wrap idx increments, and NUM_DIGITS-1 wraps to 0.
//   position and oData are registered on the same edge as idx changes, so there is no ghosting.
//   SCAN_DIV=1 advances every cycle. Scanning never stalls, including during busy.
//  Glyphs (active-low):
//   0 1000000  1 1111001  2 0100100  3 0110000  4 0011001
//   5 0010010  6 0000010  7 1111000  8 0000000  9 0010000
//   A 0001000  b 0000011  C 1000110  d 0100001  E 0000110  F 0001110
//   blank 1111111  dash 0111111
//  Blanking (BLANK_LZ=1, no overflow): digit i>0 shows blank if it and all higher digits are 0.
//   Digit 0 is never blanked.
//  Width rules: BCD shift register is 4*NUM_DIGITS bits wide. Each digit is adjusted +3 when >=5
//   before each shift. No truncation warning beyond the overflow flag.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, IN_W=16 unless noted)
//  1 rst_n=0 3 cycles -> position=4'b1110, oData=1000000, busy=0; each digit held 4 cycles;
//    digits1-3 show 1111111.
//  2 load value=1234 mode=0 -> busy=1 for 16 cycles; then digit0..3 =
//    0011001, 0110000, 0100100, 1111001.
//  3 load value=16'h00AF mode=1 -> busy=1 1 cycle; digit0=0001110, digit1=0001000,
//    digits2-3 = 1111111.
//  4 load value=10000 mode=0 -> all four digits 0111111; then load 16'h1_0000 is not
//    representable at IN_W=16, so rerun with IN_W=20, mode=1 -> all dashes.
//  5 load 1234, pulse load value=42 at busy cycle 5 -> ignored, 1234 shown;
//    new load 99, rst_n=0 at busy cycle 8 -> busy=0, display shows 0.
//  6 load value=7 mode=0 -> digit0=1111000, others blank; BLANK_LZ=0 -> digits1-3 = 1000000.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment driver.
// A binary value captured on 'load' is converted to BCD one double-dabble
// step per cycle (decimal mode) or passed through as nibbles (hex mode).
// The digit registers update atomically when busy falls. The digits are
// time-multiplexed, with leading-zero blanking and an overflow dash display.
// Ports:
//   clk       system clock, posedge
//   rst_n     synchronous reset, active-low
//   load      1-cycle capture strobe, ignored while busy
//   value     binary value to display
//   mode      0 = decimal, 1 = hex
//   busy      conversion in progress
//   oData     segments {g,f,e,d,c,b,a}, active-low, registered
//   position  digit select, active-low one-hot, bit0 = least significant digit
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned IN_W       = 20,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [IN_W-1:0]       value,
    input  logic                  mode,
    output logic                  busy,
    output logic [6:0]            oData,
    output logic [NUM_DIGITS-1:0] position
);

    localparam int unsigned DW  = 4 * NUM_DIGITS;
    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW  = $clog2(IN_W + 1);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;

    // Largest decimal value that fits in NUM_DIGITS digits.
    function automatic logic [63:0] dec_max(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = dec_max(NUM_DIGITS);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEC,
        S_HEX
    } state_t;

    state_t          state_q, state_d;
    logic            capture, finish;
    logic [IN_W-1:0] bin_q;
    logic [DW-1:0]   bcd_q, bcd_adj, bcd_shift;
    logic [CW-1:0]   step_q;
    logic            ovf_cap_q, ovf_cap_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic            ovf_q, ovf_d;
    logic [SCW-1:0]  scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NUM_DIGITS-1:0] zero_above;
    logic [3:0]      nib_sel;
    logic [6:0]      odata_d;
    logic [NUM_DIGITS-1:0] position_d;
    logic [63:0]     v64;

    // Next-state logic: one double-dabble step per cycle in S_DEC, one cycle in S_HEX.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    state_d = mode ? S_HEX : S_DEC;
                end
            end
            S_DEC: begin
                if (step_q == CW'(IN_W - 1)) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HEX: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Overflow is decided on the raw captured value.
    always_comb begin
        v64       = 64'(value);
        ovf_cap_d = mode ? ((v64 >> DW) != 64'd0) : (v64 > MAX_DEC);
    end

    // Add-3 adjust then shift in the next binary MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[DW-2:0], bin_q[IN_W-1]};
    end

    // Atomic digit update on the final step.
    always_comb begin
        digits_d = digits_q;
        ovf_d    = ovf_q;
        if (finish) begin
            ovf_d    = ovf_cap_q;
            digits_d = (state_q == S_HEX) ? DW'(bin_q) : bcd_shift;
        end
    end

    // Scan counter and digit index.
    always_comb begin
        scan_d = scan_q + SCW'(1);
        idx_d  = idx_q;
        if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Glyph for the digit selected next cycle, so position and oData change together.
    always_comb begin
        zero_above = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (i == int'(NUM_DIGITS) - 1) begin
                zero_above[i] = (digits_d[4*i +: 4] == 4'd0);
            end else begin
                zero_above[i] = zero_above[i+1] && (digits_d[4*i +: 4] == 4'd0);
            end
        end
        nib_sel    = digits_d[4*int'(idx_d) +: 4];
        position_d = ~(NUM_DIGITS'(1) << idx_d);
        if (ovf_d) begin
            odata_d = GLYPH_DASH;
        end else if ((BLANK_LZ != 0) && (idx_d != '0) && zero_above[idx_d]) begin
            odata_d = GLYPH_BLANK;
        end else begin
            odata_d = glyph(nib_sel);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
        end
    end

    // Conversion datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            step_q    <= '0;
            ovf_cap_q <= 1'b0;
        end else if (capture) begin
            bin_q     <= value;
            bcd_q     <= '0;
            step_q    <= '0;
            ovf_cap_q <= ovf_cap_d;
        end else if (state_q == S_DEC) begin
            bin_q  <= bin_q << 1;
            bcd_q  <= bcd_shift;
            step_q <= step_q + CW'(1);
        end
    end

    // Display registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            scan_q   <= '0;
            idx_q    <= '0;
            position <= ~NUM_DIGITS'(1);
            oData    <= GLYPH_ZERO;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            position <= position_d;
            oData    <= odata_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4).
// Three instances: IN_W=16 blanking, IN_W=16 no blanking, IN_W=20 blanking.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        load_a = 1'b0;
    logic [15:0] value_a = '0;
    logic        load_b = 1'b0;
    logic [19:0] value_b = '0;

    logic       busy_a, busy_n, busy_b;
    logic [6:0] odata_a, odata_n, odata_b;
    logic [3:0] pos_a, pos_n, pos_b;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          sel;
        logic [27:0] g;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .IN_W(16), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load_a), .value(value_a), .mode(mode),
        .busy(busy_a), .oData(odata_a), .position(pos_a));

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .IN_W(16), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst_n(rst_n), .load(load_a), .value(value_a), .mode(mode),
        .busy(busy_n), .oData(odata_n), .position(pos_n));

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .IN_W(20), .BLANK_LZ(1)) u_w20 (
        .clk(clk), .rst_n(rst_n), .load(load_b), .value(value_b), .mode(mode),
        .busy(busy_b), .oData(odata_b), .position(pos_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Reference display frame for a 4-digit display, digit0 in bits [6:0].
    function automatic logic [27:0] ref_frame(input longint v, input bit m, input bit blz);
        int          d[4];
        bit          ovf;
        bit          zero_up;
        logic [27:0] f;
        ovf = m ? (v >= 64'h10000) : (v > 9999);
        for (int i = 0; i < 4; i++) begin
            d[i] = m ? int'((v >> (4*i)) & 15) : int'((v / (10 ** i)) % 10);
        end
        for (int i = 0; i < 4; i++) begin
            zero_up = 1'b1;
            for (int j = i; j < 4; j++) if (d[j] != 0) zero_up = 1'b0;
            if (ovf)                          f[7*i +: 7] = 7'b0111111;
            else if (blz && i > 0 && zero_up) f[7*i +: 7] = 7'b1111111;
            else                              f[7*i +: 7] = ref_glyph(d[i]);
        end
        return f;
    endfunction

    function automatic logic [3:0] pos_of(input int sel);
        return (sel == 0) ? pos_a : (sel == 1) ? pos_n : pos_b;
    endfunction

    function automatic logic [6:0] dat_of(input int sel);
        return (sel == 0) ? odata_a : (sel == 1) ? odata_n : odata_b;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_n : busy_b;
    endfunction

    task automatic push_exp(input int sel, input longint v, input bit m, input bit blz,
                            input string tag);
        exp_t e;
        e.sel = sel;
        e.g   = ref_frame(v, m, blz);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Record one full scan frame starting at the next entry into digit0.
    task automatic grab_frame(input int sel, output logic [27:0] g, output bit ok);
        logic [3:0] prev, cur;
        bit         found;
        g     = '0;
        ok    = 1'b0;
        found = 1'b0;
        prev  = pos_of(sel);
        for (int n = 0; n < 64 && !found; n++) begin
            tick();
            cur = pos_of(sel);
            if (cur == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = cur;
        end
        if (!found) return;
        ok = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(d == 0 && c == 0)) tick();
                if (pos_of(sel) != 4'(~(4'b0001 << d))) ok = 1'b0;
                if (c == 0) g[7*d +: 7] = dat_of(sel);
                else if (dat_of(sel) != g[7*d +: 7]) ok = 1'b0;
            end
        end
    endtask

    // Pop the oldest expected frame and compare it with what the DUT scans out.
    task automatic check_frame();
        exp_t        e;
        logic [27:0] g;
        bit          ok;
        e = sb.pop_front();
        grab_frame(e.sel, g, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL %s scan_dwell: actual ok=%0b required ok=1", e.tag, ok);
        else n_pass++;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (g[7*d +: 7] !== e.g[7*d +: 7])
                $display("FAIL %s digit%0d: actual %b required %b", e.tag, d, g[7*d +: 7], e.g[7*d +: 7]);
            else n_pass++;
        end
    endtask

    task automatic count_busy(input int sel, output int n);
        n = 0;
        while (busy_of(sel) === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_busy(input string tag, input int n, input int req);
        n_checks++;
        if (n !== req) $display("FAIL %s busy_cycles: actual %0d required %0d", tag, n, req);
        else n_pass++;
    endtask

    task automatic load_main(input logic [15:0] v, input logic m);
        value_a = v;
        mode    = m;
        load_a  = 1'b1;
        tick();
        load_a  = 1'b0;
    endtask

    task automatic load_w20(input logic [19:0] v, input logic m);
        value_b = v;
        mode    = m;
        load_b  = 1'b1;
        tick();
        load_b  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (pos_a !== 4'b1110) $display("FAIL reset position: actual %b required 1110", pos_a);
        else n_pass++;
        n_checks++;
        if (odata_a !== 7'b1000000) $display("FAIL reset oData: actual %b required 1000000", odata_a);
        else n_pass++;
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL reset busy: actual %b required 0", busy_a);
        else n_pass++;
        rst_n = 1'b1;
        push_exp(0, 0, 1'b0, 1'b1, "reset_frame");
        check_frame();
    endtask

    task automatic test_decimal();
        int n;
        load_main(16'd1234, 1'b0);
        push_exp(0, 1234, 1'b0, 1'b1, "dec_1234");
        count_busy(0, n);
        check_busy("dec_1234", n, 16);
        check_frame();
    endtask

    task automatic test_hex();
        int n;
        load_main(16'h00AF, 1'b1);
        push_exp(0, 'hAF, 1'b1, 1'b1, "hex_00AF");
        count_busy(0, n);
        check_busy("hex_00AF", n, 1);
        check_frame();
    endtask

    task automatic test_overflow();
        int n;
        load_main(16'd10000, 1'b0);
        push_exp(0, 10000, 1'b0, 1'b1, "dec_10000_ovf");
        count_busy(0, n);
        check_busy("dec_10000_ovf", n, 16);
        check_frame();
        load_main(16'd9999, 1'b0);
        push_exp(0, 9999, 1'b0, 1'b1, "dec_9999");
        count_busy(0, n);
        check_busy("dec_9999", n, 16);
        check_frame();
        load_w20(20'h10000, 1'b1);
        push_exp(2, 'h10000, 1'b1, 1'b1, "w20_hex_10000_ovf");
        count_busy(2, n);
        check_busy("w20_hex_10000_ovf", n, 1);
        check_frame();
        load_w20(20'h0FFFF, 1'b1);
        push_exp(2, 'hFFFF, 1'b1, 1'b1, "w20_hex_FFFF");
        count_busy(2, n);
        check_busy("w20_hex_FFFF", n, 1);
        check_frame();
    endtask

    task automatic test_busy_ignore_and_reset();
        int n;
        load_main(16'd1234, 1'b0);
        repeat (4) tick();
        value_a = 16'd42;
        load_a  = 1'b1;
        tick();
        load_a  = 1'b0;
        count_busy(0, n);
        check_busy("ignored_load_remaining", n, 11);
        repeat (3) tick();
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL ignored_load_queued busy: actual %b required 0", busy_a);
        else n_pass++;
        push_exp(0, 1234, 1'b0, 1'b1, "ignored_load_1234");
        check_frame();
        load_main(16'd99, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL abort busy_in_reset: actual %b required 0", busy_a);
        else n_pass++;
        rst_n = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL abort busy_after_reset: actual %b required 0", busy_a);
        else n_pass++;
        push_exp(0, 0, 1'b0, 1'b1, "abort_shows_0");
        check_frame();
    endtask

    task automatic test_blanking();
        int n;
        load_main(16'd7, 1'b0);
        push_exp(0, 7, 1'b0, 1'b1, "blank_lz1_7");
        push_exp(1, 7, 1'b0, 1'b0, "blank_lz0_7");
        count_busy(0, n);
        check_busy("blank_7", n, 16);
        check_frame();
        check_frame();
    endtask

    task automatic test_back_to_back();
        int         n;
        logic [3:0] p0;
        load_main(16'd8, 1'b0);
        p0 = pos_a;
        repeat (4) tick();
        n_checks++;
        if (pos_a === p0) $display("FAIL scan_during_busy position: actual %b required change from %b", pos_a, p0);
        else n_pass++;
        count_busy(0, n);
        check_busy("b2b_dec_8", n, 12);
        load_main(16'hBEEF, 1'b1);
        push_exp(0, 'hBEEF, 1'b1, 1'b1, "b2b_hex_BEEF");
        count_busy(0, n);
        check_busy("b2b_hex_BEEF", n, 1);
        check_frame();
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_busy_ignore_and_reset();
        test_blanking();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
